// File: rtl/game_round_controller.sv
// Round sequencer for the target/torpedo game: arms sprites, fires the
// torpedo on request, scores hits and misses and shows each result for a
// fixed number of cycles before the next round or the game-over screen.
`timescale 1ns/1ps

module game_round_controller #(
    parameter int                unsigned w_x        = 10,
    parameter int                unsigned w_y        = 9,
    parameter int                unsigned TARGET_X0  = 0,
    parameter int                unsigned TARGET_Y0  = 0,
    parameter logic signed [1:0] TARGET_DX           = 2'sb01,
    parameter logic signed [1:0] TARGET_DY           = 2'sb00,
    parameter int                unsigned TORPEDO_X0 = 316,
    parameter int                unsigned TORPEDO_Y0 = 472,
    parameter logic signed [1:0] TORPEDO_DX          = 2'sb00,
    parameter logic signed [1:0] TORPEDO_DY          = 2'sb11,
    parameter int                unsigned END_HOLD   = 50_000_000,
    parameter int                unsigned MAX_MISSES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_start,
    input  logic                  key_launch,
    input  logic                  collision,
    input  logic                  torpedo_hit_wall,
    output logic                  target_write_xy,
    output logic                  target_write_dxy,
    output logic                  target_enable_update,
    output logic                  torpedo_write_xy,
    output logic                  torpedo_write_dxy,
    output logic                  torpedo_enable_update,
    output logic [w_x-1:0]        target_x,
    output logic [w_y-1:0]        target_y,
    output logic [w_x-1:0]        torpedo_x,
    output logic [w_y-1:0]        torpedo_y,
    output logic signed [1:0]     target_dx,
    output logic signed [1:0]     target_dy,
    output logic signed [1:0]     torpedo_dx,
    output logic signed [1:0]     torpedo_dy,
    output logic [3:0]            score,
    output logic [3:0]            misses,
    output logic                  state_win,
    output logic                  state_miss,
    output logic                  game_over
);

    localparam int unsigned HW = $clog2(END_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, START, AIM, SHOOT, FLIGHT, WIN, MISS, OVER
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   score_q, score_d;
    logic [3:0]   misses_q, misses_d;
    logic [HW-1:0] hold_q, hold_d;
    logic         startPrev_q, launchPrev_q, armed_q;
    logic         startEdge, launchEdge;

    // Registered output copies, loaded from the decode of the next state.
    logic [8:0]   outs_q, outs_d;

    assign target_x   = w_x'(TARGET_X0);
    assign target_y   = w_y'(TARGET_Y0);
    assign torpedo_x  = w_x'(TORPEDO_X0);
    assign torpedo_y  = w_y'(TORPEDO_Y0);
    assign target_dx  = TARGET_DX;
    assign target_dy  = TARGET_DY;
    assign torpedo_dx = TORPEDO_DX;
    assign torpedo_dy = TORPEDO_DY;

    // Edges are suppressed on the first clock after reset so a key held
    // through reset release cannot start or fire anything.
    assign startEdge  = key_start  & ~startPrev_q  & armed_q;
    assign launchEdge = key_launch & ~launchPrev_q & armed_q;

    assign {target_write_xy, target_write_dxy, target_enable_update,
            torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update,
            state_win, state_miss, game_over} = outs_q;
    assign score  = score_q;
    assign misses = misses_q;

    // State, counters, key history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= 4'd0;
            misses_q     <= 4'd0;
            hold_q       <= '0;
            startPrev_q  <= 1'b0;
            launchPrev_q <= 1'b0;
            armed_q      <= 1'b0;
            outs_q       <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hold_q       <= hold_d;
            startPrev_q  <= key_start;
            launchPrev_q <= key_launch;
            armed_q      <= 1'b1;
            outs_q       <= outs_d;
        end
    end

    // Next-state, counter updates and output decode of the next state.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        misses_d = misses_q;
        hold_d   = hold_q;
        outs_d   = '0;
        case (state_q)
            IDLE, OVER: begin
                if (startEdge) begin
                    state_d  = START;
                    score_d  = 4'd0;
                    misses_d = 4'd0;
                end
            end
            START: state_d = AIM;
            AIM: begin
                if (launchEdge) state_d = SHOOT;
            end
            SHOOT: state_d = FLIGHT;
            FLIGHT: begin
                if (collision) begin
                    state_d = WIN;
                    hold_d  = '0;
                    if (score_q != 4'd15) score_d = score_q + 4'd1;
                end else if (torpedo_hit_wall) begin
                    state_d = MISS;
                    hold_d  = '0;
                    if (misses_q != 4'd15) misses_d = misses_q + 4'd1;
                end
            end
            WIN: begin
                if (hold_q == HOLD_LAST) state_d = START;
                else                     hold_d  = hold_q + HW'(1);
            end
            MISS: begin
                if (hold_q == HOLD_LAST)
                    state_d = (misses_q == 4'(MAX_MISSES)) ? OVER : START;
                else
                    hold_d = hold_q + HW'(1);
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   outs_d = 9'b110_110_000;
            AIM:     outs_d = 9'b001_000_000;
            SHOOT:   outs_d = 9'b001_110_000;
            FLIGHT:  outs_d = 9'b001_001_000;
            WIN:     outs_d = 9'b000_000_100;
            MISS:    outs_d = 9'b000_000_010;
            OVER:    outs_d = 9'b000_000_001;
            default: outs_d = 9'b000_000_000;
        endcase
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Testbench for game_round_controller: fixed vector table for a full game,
// hand sequences for key-hold and reset corner cases, then random play
// compared with a behavioural model of the game rules.
`timescale 1ns/1ps

module tb_game_round_controller;

    localparam int END_HOLD   = 4;
    localparam int MAX_MISSES = 2;

    // Flag order: tWxy tWdxy tEn pWxy pWdxy pEn win miss over
    localparam logic [8:0] F_IDLE   = 9'b000_000_000;
    localparam logic [8:0] F_START  = 9'b110_110_000;
    localparam logic [8:0] F_AIM    = 9'b001_000_000;
    localparam logic [8:0] F_SHOOT  = 9'b001_110_000;
    localparam logic [8:0] F_FLIGHT = 9'b001_001_000;
    localparam logic [8:0] F_WIN    = 9'b000_000_100;
    localparam logic [8:0] F_MISS   = 9'b000_000_010;
    localparam logic [8:0] F_OVER   = 9'b000_000_001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_start = 1'b0, key_launch = 1'b0, collision = 1'b0, torpedo_hit_wall = 1'b0;
    logic target_write_xy, target_write_dxy, target_enable_update;
    logic torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update;
    logic [9:0] target_x, torpedo_x;
    logic [8:0] target_y, torpedo_y;
    logic signed [1:0] target_dx, target_dy, torpedo_dx, torpedo_dy;
    logic [3:0] score, misses;
    logic state_win, state_miss, game_over;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    game_round_controller #(.END_HOLD(END_HOLD), .MAX_MISSES(MAX_MISSES)) dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_launch(key_launch),
        .collision(collision), .torpedo_hit_wall(torpedo_hit_wall),
        .target_write_xy(target_write_xy), .target_write_dxy(target_write_dxy),
        .target_enable_update(target_enable_update),
        .torpedo_write_xy(torpedo_write_xy), .torpedo_write_dxy(torpedo_write_dxy),
        .torpedo_enable_update(torpedo_enable_update),
        .target_x(target_x), .target_y(target_y),
        .torpedo_x(torpedo_x), .torpedo_y(torpedo_y),
        .target_dx(target_dx), .target_dy(target_dy),
        .torpedo_dx(torpedo_dx), .torpedo_dy(torpedo_dy),
        .score(score), .misses(misses),
        .state_win(state_win), .state_miss(state_miss), .game_over(game_over)
    );

    logic [8:0] actFlags;
    assign actFlags = {target_write_xy, target_write_dxy, target_enable_update,
                       torpedo_write_xy, torpedo_write_dxy, torpedo_enable_update,
                       state_win, state_miss, game_over};

    typedef struct {
        bit         ks, kl, col, wall;
        logic [8:0] expFlags;
        logic [3:0] expScore, expMisses;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model of the game rules.
    typedef enum {M_IDLE, M_START, M_AIM, M_SHOOT, M_FLIGHT, M_WIN, M_MISS, M_OVER} phase_t;
    phase_t mPhase;
    int mScore, mMisses, mLeft;
    bit mPrevS, mPrevL, mArmed;

    function automatic logic [8:0] phaseFlags(phase_t p);
        case (p)
            M_START:  return F_START;
            M_AIM:    return F_AIM;
            M_SHOOT:  return F_SHOOT;
            M_FLIGHT: return F_FLIGHT;
            M_WIN:    return F_WIN;
            M_MISS:   return F_MISS;
            M_OVER:   return F_OVER;
            default:  return F_IDLE;
        endcase
    endfunction

    task automatic modelReset();
        mPhase = M_IDLE; mScore = 0; mMisses = 0; mLeft = 0;
        mPrevS = 0; mPrevL = 0; mArmed = 0;
    endtask

    task automatic modelStep(input bit ks, input bit kl, input bit col, input bit wall);
        bit sEdge, lEdge;
        sEdge = ks && !mPrevS && mArmed;
        lEdge = kl && !mPrevL && mArmed;
        mPrevS = ks; mPrevL = kl; mArmed = 1;
        case (mPhase)
            M_IDLE, M_OVER: if (sEdge) begin mPhase = M_START; mScore = 0; mMisses = 0; end
            M_START:  mPhase = M_AIM;
            M_AIM:    if (lEdge) mPhase = M_SHOOT;
            M_SHOOT:  mPhase = M_FLIGHT;
            M_FLIGHT: begin
                if (col) begin
                    mPhase = M_WIN; mLeft = END_HOLD;
                    mScore = (mScore < 15) ? mScore + 1 : 15;
                end else if (wall) begin
                    mPhase = M_MISS; mLeft = END_HOLD;
                    mMisses = (mMisses < 15) ? mMisses + 1 : 15;
                end
            end
            M_WIN: begin
                mLeft--;
                if (mLeft == 0) mPhase = M_START;
            end
            M_MISS: begin
                mLeft--;
                if (mLeft == 0) mPhase = (mMisses == MAX_MISSES) ? M_OVER : M_START;
            end
            default: mPhase = M_IDLE;
        endcase
    endtask

    // Drive one cycle of inputs and sample just after the clock edge.
    task automatic applyStimulus(input bit ks, input bit kl, input bit col, input bit wall);
        @(negedge clk);
        key_start = ks; key_launch = kl; collision = col; torpedo_hit_wall = wall;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] expFlags,
                               input logic [3:0] expScore, input logic [3:0] expMisses);
        testCount++;
        if (actFlags !== expFlags || score !== expScore || misses !== expMisses) begin
            failCount++;
            $display("[TB] FAIL %s: got flags=%b score=%0d misses=%0d, expected flags=%b score=%0d misses=%0d",
                     name, actFlags, score, misses, expFlags, expScore, expMisses);
        end
    endtask

    task automatic doReset(input bit ks, input bit kl);
        @(negedge clk);
        rst = 1'b1;
        key_start = ks; key_launch = kl; collision = 0; torpedo_hit_wall = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", F_IDLE, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic addVec(input bit ks, input bit kl, input bit col, input bit wall,
                          input logic [8:0] f, input int s, input int m);
        vec_t v;
        v.ks = ks; v.kl = kl; v.col = col; v.wall = wall;
        v.expFlags = f; v.expScore = 4'(s); v.expMisses = 4'(m);
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Full game: win, miss, simultaneous hit+wall, miss, game over, restart.
        addVec(1,0,0,0, F_START, 0,0);
        addVec(0,0,0,0, F_AIM,   0,0);
        addVec(0,1,0,0, F_SHOOT, 0,0);
        addVec(0,0,0,0, F_FLIGHT,0,0);
        addVec(0,0,0,0, F_FLIGHT,0,0);
        addVec(0,0,1,0, F_WIN,   1,0);
        addVec(0,0,0,0, F_WIN,   1,0);
        addVec(0,0,0,0, F_WIN,   1,0);
        addVec(0,0,0,0, F_WIN,   1,0);
        addVec(0,0,0,0, F_START, 1,0);
        addVec(0,0,0,0, F_AIM,   1,0);
        addVec(0,1,0,0, F_SHOOT, 1,0);
        addVec(0,0,0,0, F_FLIGHT,1,0);
        addVec(0,0,0,1, F_MISS,  1,1);
        addVec(0,0,0,0, F_MISS,  1,1);
        addVec(0,0,0,0, F_MISS,  1,1);
        addVec(0,0,0,0, F_MISS,  1,1);
        addVec(0,0,0,0, F_START, 1,1);
        addVec(0,0,0,0, F_AIM,   1,1);
        addVec(0,1,0,0, F_SHOOT, 1,1);
        addVec(0,0,0,0, F_FLIGHT,1,1);
        addVec(0,0,1,1, F_WIN,   2,1);
        addVec(0,0,0,0, F_WIN,   2,1);
        addVec(0,0,0,0, F_WIN,   2,1);
        addVec(0,0,0,0, F_WIN,   2,1);
        addVec(0,0,0,0, F_START, 2,1);
        addVec(0,0,0,0, F_AIM,   2,1);
        addVec(0,1,0,0, F_SHOOT, 2,1);
        addVec(0,0,0,0, F_FLIGHT,2,1);
        addVec(0,0,0,1, F_MISS,  2,2);
        addVec(0,0,0,1, F_MISS,  2,2);
        addVec(0,0,0,0, F_MISS,  2,2);
        addVec(0,0,0,0, F_MISS,  2,2);
        addVec(0,0,0,0, F_OVER,  2,2);
        addVec(0,1,0,0, F_OVER,  2,2);
        addVec(0,0,0,0, F_OVER,  2,2);
        addVec(0,1,0,0, F_OVER,  2,2);
        addVec(1,0,0,0, F_START, 0,0);
        addVec(0,0,0,0, F_AIM,   0,0);
        addVec(1,0,0,0, F_AIM,   0,0);
        addVec(0,0,0,0, F_AIM,   0,0);

        doReset(0, 0);
        testCount++;
        if (target_x !== 10'd0 || target_y !== 9'd0 || torpedo_x !== 10'd316 ||
            torpedo_y !== 9'd472 || target_dx !== 2'sb01 || target_dy !== 2'sb00 ||
            torpedo_dx !== 2'sb00 || torpedo_dy !== 2'sb11) begin
            failCount++;
            $display("[TB] FAIL constants: got tx=%0d ty=%0d px=%0d py=%0d tdx=%0d tdy=%0d pdx=%0d pdy=%0d, expected 0 0 316 472 1 0 0 -1",
                     target_x, target_y, torpedo_x, torpedo_y, target_dx, target_dy, torpedo_dx, torpedo_dy);
        end
        applyStimulus(0,0,0,0);
        checkOutput("idle_after_reset", F_IDLE, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ks, vecs[i].kl, vecs[i].col, vecs[i].wall);
            checkOutput($sformatf("vec%0d", i), vecs[i].expFlags, vecs[i].expScore, vecs[i].expMisses);
        end

        // Start key held high through reset release must not start a game.
        doReset(1, 0);
        applyStimulus(1,0,0,0);
        checkOutput("start_held_reset_c1", F_IDLE, 0, 0);
        applyStimulus(1,0,0,0);
        checkOutput("start_held_reset_c2", F_IDLE, 0, 0);

        // Launch key held from idle through start: no shot until re-pressed.
        doReset(0, 1);
        applyStimulus(0,1,0,0);
        applyStimulus(1,1,0,0);
        checkOutput("launch_held_start", F_START, 0, 0);
        applyStimulus(0,1,0,0);
        checkOutput("launch_held_aim1", F_AIM, 0, 0);
        applyStimulus(0,1,0,0);
        checkOutput("launch_held_aim2", F_AIM, 0, 0);
        applyStimulus(0,0,0,0);
        checkOutput("launch_released", F_AIM, 0, 0);
        applyStimulus(0,1,0,0);
        checkOutput("launch_repressed", F_SHOOT, 0, 0);
        applyStimulus(0,0,0,0);
        applyStimulus(0,0,1,0);
        checkOutput("win_before_reset", F_WIN, 1, 0);
        applyStimulus(0,0,0,0);

        // Reset during the win hold clears everything at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_win_async", F_IDLE, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(0,0,0,0);
        checkOutput("idle_after_win_reset", F_IDLE, 0, 0);
        applyStimulus(0,0,0,0);
        checkOutput("idle_after_win_reset2", F_IDLE, 0, 0);

        // Random play against the behavioural model.
        doReset(0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit ks, kl, col, wall;
            ks   = ($urandom_range(0, 11) == 0);
            kl   = ($urandom_range(0, 3)  == 0);
            col  = ($urandom_range(0, 6)  == 0);
            wall = ($urandom_range(0, 5)  == 0);
            applyStimulus(ks, kl, col, wall);
            modelStep(ks, kl, col, wall);
            checkOutput($sformatf("rand%0d", i), phaseFlags(mPhase), 4'(mScore), 4'(mMisses));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
